// File: rtl/sat_mac_pkg.sv
// +------------------------------------------------------------------+
// | sat_mac_pkg : shared helpers for the saturating MAC               |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package sat_mac_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Symmetric range: the most negative two's-complement code is never used.
  function automatic longint sat_max(input int n);
    return (longint'(1) <<< (n - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int n);
    return -sat_max(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_round.sv
// +------------------------------------------------------------------+
// | sat_round : scale accumulator by 2^-DECIM, round/floor, saturate  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module sat_round
  import sat_mac_pkg::*;
#(
  parameter int N     = 12,
  parameter int DECIM = 8,
  parameter int GUARD = 2
) (
  input  logic signed [2*N+GUARD-1:0] i_acc,
  input  logic                        i_round,
  output logic signed [N-1:0]         o_res,
  output logic                        o_sat
);

  localparam int c_aw = 2*N + GUARD;
  // One extra bit so the rounding increment can never wrap.
  localparam int c_xw = c_aw + 1;
  localparam logic signed [c_xw-1:0] c_half  = c_xw'(1) <<< (DECIM - 1);
  localparam logic signed [c_xw-1:0] c_max_x = c_xw'(sat_max(N));
  localparam logic signed [c_xw-1:0] c_min_x = c_xw'(sat_min(N));
  localparam logic signed [N-1:0]    c_max_n = N'(sat_max(N));
  localparam logic signed [N-1:0]    c_min_n = N'(sat_min(N));

  logic signed [c_xw-1:0] w_rnd;
  logic signed [c_xw-1:0] w_sh;

  assign w_rnd = c_xw'(i_acc) + (i_round ? c_half : {c_xw{1'b0}});
  assign w_sh  = w_rnd >>> DECIM;

  always_comb begin
    o_res = w_sh[N-1:0];
    o_sat = 1'b0;
    if (w_sh > c_max_x) begin
      o_res = c_max_n;
      o_sat = 1'b1;
    end else if (w_sh < c_min_x) begin
      o_res = c_min_n;
      o_sat = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sat_mac.sv
// +------------------------------------------------------------------+
// | sat_mac : two-stage saturating fixed-point multiply-accumulate    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module sat_mac
  import sat_mac_pkg::*;
#(
  parameter int N        = 12,
  parameter int DECIM    = 8,
  parameter int MAXTERMS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_a,
  input  logic signed [N-1:0] in_b,
  input  logic                in_last,
  input  logic                round_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_res,
  output logic                out_sat,
  output logic                out_forced
);

  localparam int GUARD = clog2(MAXTERMS);
  localparam int c_aw  = 2*N + GUARD;
  localparam int c_cw  = clog2(MAXTERMS) + 1;
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(MAXTERMS - 1);

  logic                  r_s1_valid;
  logic signed [N-1:0]   r_s1_a;
  logic signed [N-1:0]   r_s1_b;
  logic                  r_s1_last;
  logic                  r_s1_rnd;
  logic signed [c_aw-1:0] r_acc;
  logic [c_cw-1:0]       r_cnt;

  logic                   w_term_last;
  logic                   w_stall;
  logic                   w_s1_adv;
  logic                   w_accept;
  logic signed [2*N-1:0]  w_prod;
  logic signed [c_aw-1:0] w_sum;
  logic signed [N-1:0]    w_res;
  logic                   w_sat;

  // A term closes the sum either by in_last or by hitting the term limit.
  assign w_term_last = r_s1_last | (r_cnt == c_cnt_last);
  assign w_stall     = r_s1_valid & w_term_last & out_valid & ~out_ready;
  assign w_s1_adv    = r_s1_valid & ~w_stall;
  assign in_ready    = ~r_s1_valid | w_s1_adv;
  assign w_accept    = in_valid & in_ready;

  assign w_prod = r_s1_a * r_s1_b;
  assign w_sum  = (r_cnt == '0) ? c_aw'(w_prod) : r_acc + c_aw'(w_prod);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_last  <= 1'b0;
      r_s1_rnd   <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
      r_s1_last  <= in_last;
      r_s1_rnd   <= round_en;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_s1_adv) begin
      if (w_term_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + c_cw'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_res    <= '0;
      out_sat    <= 1'b0;
      out_forced <= 1'b0;
    end else if (w_s1_adv && w_term_last) begin
      out_valid  <= 1'b1;
      out_res    <= w_res;
      out_sat    <= w_sat;
      out_forced <= ~r_s1_last;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  sat_round #(
    .N     (N),
    .DECIM (DECIM),
    .GUARD (GUARD)
  ) u_sat_round (
    .i_acc   (w_sum),
    .i_round (r_s1_rnd),
    .o_res   (w_res),
    .o_sat   (w_sat)
  );

endmodule

`default_nettype wire

// File: tb/tb_sat_mac.sv
// +------------------------------------------------------------------+
// | tb_sat_mac : directed + randomized checks against a sum model     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_sat_mac;

  localparam int N    = 12;
  localparam int DEC  = 8;
  localparam int MAXT = 4;
  localparam longint LIM = (longint'(1) << (N - 1)) - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [N-1:0] in_a = '0;
  logic signed [N-1:0] in_b = '0;
  logic                in_last = 1'b0;
  logic                round_en = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [N-1:0] out_res;
  logic                out_sat;
  logic                out_forced;

  typedef struct {
    longint res;
    bit     sat;
    bit     forced;
  } exp_t;

  exp_t   q[$];
  longint m_sum = 0;
  int     m_cnt = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_out = 0;
  bit     hs_in = 1'b0;
  longint last_res = 0;
  bit     last_sat = 1'b0;
  bit     last_forced = 1'b0;

  sat_mac #(.N(N), .DECIM(DEC), .MAXTERMS(MAXT)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .round_en   (round_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_sat    (out_sat),
    .out_forced (out_forced)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sum model: exact integer sum, then floor/round-half-up and clip.
  task automatic model_accept();
    longint v;
    bit     closes;
    m_sum += longint'(in_a) * longint'(in_b);
    m_cnt++;
    closes = in_last || (m_cnt == MAXT);
    if (closes) begin
      v = m_sum + (round_en ? (longint'(1) << (DEC - 1)) : 0);
      v = v >>> DEC;
      if (v > LIM)       q.push_back('{LIM, 1'b1, !in_last});
      else if (v < -LIM) q.push_back('{-LIM, 1'b1, !in_last});
      else               q.push_back('{v, 1'b0, !in_last});
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  task automatic check_out();
    exp_t e;
    n_cmp++;
    assert (q.size() != 0) else begin
      n_bad++;
      $error("FAIL unexpected_result: observed %0d expected none", out_res);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("res", longint'(out_res), e.res);
      chk("sat", longint'(out_sat), longint'(e.sat));
      chk("forced", longint'(out_forced), longint'(e.forced));
    end
    last_res    = longint'(out_res);
    last_sat    = out_sat;
    last_forced = out_forced;
    n_out++;
  endtask

  task automatic cyc();
    @(negedge clk);
    if (out_valid && out_ready) check_out();
    hs_in = in_valid && in_ready;
    if (hs_in) model_accept();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input bit last, input bit rnd);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_a     = N'(a);
    in_b     = N'(b);
    in_last  = last;
    round_en = rnd;
    do begin
      cyc();
      k++;
    end while (!hs_in && k < 50);
    chk("accept", longint'(hs_in), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && k < 20) begin
      cyc();
      k++;
    end
    chk("drain_left", longint'(q.size()), 0);
  endtask

  task automatic model_reset();
    q.delete();
    m_sum = 0;
    m_cnt = 0;
  endtask

  initial begin
    int base;
    // Asynchronous reset takes effect before any clock edge.
    #1 reset = 1'b1;
    #2;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_res", longint'(out_res), 0);
    chk("rst_out_sat", longint'(out_sat), 0);
    chk("rst_out_forced", longint'(out_forced), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Single term and latency
    send(256, 384, 1'b1, 1'b0);
    chk("lat_edge1_valid", longint'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", longint'(out_valid), 1);
    chk("single_res", longint'(out_res), 384);
    chk("single_sat", longint'(out_sat), 0);
    drain();

    // Positive and negative saturation
    send(1024, 1024, 1'b0, 1'b0);
    send(1024, 1024, 1'b0, 1'b0);
    send(1024, 1024, 1'b1, 1'b0);
    drain();
    chk("sat_pos_res", last_res, 2047);
    chk("sat_pos_flag", longint'(last_sat), 1);
    send(-1024, 1024, 1'b0, 1'b0);
    send(-1024, 1024, 1'b0, 1'b0);
    send(-1024, 1024, 1'b1, 1'b0);
    drain();
    chk("sat_neg_res", last_res, -2047);
    chk("sat_neg_flag", longint'(last_sat), 1);

    // Rounding versus floor at the half-LSB point
    send(1, 128, 1'b1, 1'b0);  drain(); chk("floor_pos", last_res, 0);
    send(1, 128, 1'b1, 1'b1);  drain(); chk("round_pos", last_res, 1);
    send(-1, 128, 1'b1, 1'b0); drain(); chk("floor_neg", last_res, -1);
    send(-1, 128, 1'b1, 1'b1); drain(); chk("round_neg", last_res, 0);

    // Backpressure: result held, stage 1 stalls, nothing lost
    out_ready = 1'b0;
    base = n_out;
    send(256, 256, 1'b1, 1'b0);
    send(512, 256, 1'b1, 1'b0);
    chk("bp_in_ready", longint'(in_ready), 0);
    chk("bp_hold_valid", longint'(out_valid), 1);
    chk("bp_hold_res", longint'(out_res), 256);
    repeat (3) cyc();
    chk("bp_still_res", longint'(out_res), 256);
    drain();
    chk("bp_count", longint'(n_out - base), 2);
    chk("bp_last_res", last_res, 512);

    // Forced termination at the term limit
    repeat (4) send(256, 256, 1'b0, 1'b0);
    drain();
    chk("forced_res", last_res, 1024);
    chk("forced_flag", longint'(last_forced), 1);
    send(256, 256, 1'b1, 1'b0);
    drain();
    chk("after_forced_res", last_res, 256);
    chk("after_forced_flag", longint'(last_forced), 0);

    // Reset in the middle of a sum with a result pending
    out_ready = 1'b0;
    send(384, 256, 1'b1, 1'b0);
    send(256, 256, 1'b0, 1'b0);
    send(256, 256, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_res", longint'(out_res), 0);
    chk("mid_rst_sat", longint'(out_sat), 0);
    chk("mid_rst_forced", longint'(out_forced), 0);
    chk("mid_rst_ready", longint'(in_ready), 1);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    send(256, 256, 1'b1, 1'b0);
    drain();
    chk("post_rst_res", last_res, 256);

    // Randomized traffic with random backpressure
    hs_in = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!in_valid || hs_in) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = N'($urandom);
        in_b     = N'($urandom);
        in_last  = ($urandom_range(0, 2) == 0);
        round_en = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sat_mac.md
SAT_MAC -- requirements
Module: sat_mac

Interface
REQ-001 Parameter N, default 12: operand and result width, two's complement.
REQ-002 Parameter DECIM, default 8: fractional bits of operands and result (Q(N-DECIM).DECIM).
REQ-003 Parameter MAXTERMS, default 4: maximum products per sum; GUARD = clog2(MAXTERMS) accumulator guard bits.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  term present on in_a/in_b/in_last.
REQ-007 in_ready  out  1  term accepted on edge where in_valid & in_ready.
REQ-008 in_a, in_b  in  N  signed fixed-point operands.
REQ-009 in_last  in  1  final term of current sum.
REQ-010 round_en  in  1  1 = round half-up, 0 = truncate (floor); sampled with each term, last term's value applies.
REQ-011 out_valid  out  1  result held until out_ready.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 out_res  out  N  signed saturated sum of products.
REQ-014 out_sat  out  1  result was clipped.
REQ-015 out_forced  out  1  sum terminated by MAXTERMS, not in_last.

Function
REQ-016 Stage 1 SHALL register in_a, in_b, in_last, round_en on accept; s1_valid set.
REQ-017 Stage 2 SHALL form the full 2N-bit signed product of stage-1 operands and add it to a (2N+GUARD)-bit accumulator; first term of a sum loads accumulator with product (no clear bubble).
REQ-018 On the stage-2 edge of a last term, out_res/out_sat/out_forced SHALL load and out_valid SHALL set; latency = 2 edges from accept edge to out_valid high.
REQ-019 Scaling: acc arithmetic-shifted right by DECIM; round_en=1 adds 2^(DECIM-1) before shift.
REQ-020 Saturation SHALL be symmetric: above 2^(N-1)-1 -> 2^(N-1)-1, below -(2^(N-1)-1) -> -(2^(N-1)-1), out_sat=1; -2^(N-1) never produced.
REQ-021 A term counter SHALL count terms in current sum; term number MAXTERMS SHALL be treated as last with out_forced=1; counter resets after every last.
REQ-022 Stage 1 SHALL stall when s1_valid & s1_last & out_valid & ~out_ready; in_ready = ~s1_valid | stage-1 advancing.
REQ-023 out_valid SHALL clear on out_valid & out_ready unless a new result loads the same edge (then stays high with new value).
REQ-024 Back-to-back single-term sums SHALL sustain one term per clock when out_ready=1.
REQ-025 No term or result SHALL be dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-026 reset SHALL immediately clear s1_valid, accumulator, term counter, out_valid, out_res, out_sat, out_forced to 0; in_ready=1 after reset.
REQ-027 Reset mid-sum SHALL discard partial sum; first term accepted after release starts a new sum.

Structure
REQ-028 Package sat_mac_pkg SHALL hold sat_max/sat_min constant functions of N and the clog2 helper.
REQ-029 Scaling/rounding/saturation SHALL be one combinational sub-module sat_round (params N, DECIM, GUARD).

Verification (N=12, DECIM=8, MAXTERMS=4)
REQ-030 Single term a=256, b=384, last, round_en=0 -> out_res=384, out_sat=0, out_valid high 2 edges after accept.
REQ-031 Three terms 1024*1024, last on third -> out_res=2047, out_sat=1; same with a=-1024 -> out_res=-2047, out_sat=1.
REQ-032 a=1,b=128: round_en=0 -> 0, round_en=1 -> 1; a=-1,b=128: round_en=0 -> -1, round_en=1 -> 0.
REQ-033 out_ready=0, two single-term sums (256*256, 512*256) back-to-back -> 256 held, in_ready low after stage 1 fills; release -> 256 then 512, no loss.
REQ-034 Five terms 256*256, no in_last -> result 1024 with out_forced=1 after term 4; term 5 starts new sum.
REQ-035 reset asserted after 2 terms of a sum -> all outputs 0 immediately; next sum 256*256 last -> 256.
